matrix_alu_core: RTL and testbench

- Parametrised matrix arithmetic engine between the control FSM and matrix storage.
- Loads up to two operands from storage into internal buffers, computes, writes the result back contiguously and row-major, then pulses done.
- Over the fixed 5x5/32-bit engine it adds: configurable width and max dimension, subtraction, operand validation with error codes, a busy/status handshake, result-dimension reporting and configurable read latency.

---
 rtl/matrix_alu_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_matrix_alu_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_core.sv
// matrix_alu_core: loads one or two matrix operands from storage into local
// buffers, computes transpose/add/sub/scalar-mul/matrix-mul, writes the
// row-major result back contiguously, then pulses o_done with status.
module matrix_alu_core #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [3:0]        i_a_m,
    input  logic [3:0]        i_a_n,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [3:0]        i_b_m,
    input  logic [3:0]        i_b_n,
    input  logic [DATA_W-1:0] i_scalar,
    input  logic [ADDR_W-1:0] i_res_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err,
    output logic [3:0]        o_res_m,
    output logic [3:0]        o_res_n,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata
);

    localparam int DEPTH  = MAX_DIM * MAX_DIM;
    localparam int BUF_AW = $clog2(DEPTH);
    localparam int CNT_W  = 8;
    localparam logic [3:0]       MAX_DIM4 = 4'(MAX_DIM);
    localparam logic [CNT_W-1:0] LAT      = CNT_W'(RD_LAT);

    localparam logic [2:0] OP_TRN = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SCL = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD_A, S_LOAD_B, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Operand descriptor captured at start acceptance
    logic [2:0]        op_reg;
    logic [ADDR_W-1:0] a_addr_reg, b_addr_reg, res_addr_reg;
    logic [3:0]        a_m_reg, a_n_reg, b_m_reg, b_n_reg;
    logic [DATA_W-1:0] scalar_reg;

    // Status and sequencing
    logic [1:0]        err_reg;
    logic [3:0]        res_m_reg, res_n_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [3:0]        row_reg, col_reg, k_reg;
    logic [DATA_W-1:0] acc_reg;

    // Local operand and result buffers (no reset so they map to memory)
    logic [DATA_W-1:0] a_buf [DEPTH];
    logic [DATA_W-1:0] b_buf [DEPTH];
    logic [DATA_W-1:0] r_buf [DEPTH];

    function automatic logic bad_dim(input logic [3:0] d);
        return (d == 4'd0) || (d > MAX_DIM4);
    endfunction

    logic              accept;
    logic              need_b;
    logic [1:0]        err_calc;
    logic [3:0]        calc_m, calc_n;
    logic [CNT_W-1:0]  elems_a, elems_b, elems_r, load_elems;
    logic [ADDR_W-1:0] load_base;
    logic              in_load, load_last, mul_store, calc_step, calc_last, write_last;
    logic [BUF_AW-1:0] elem_idx, trn_idx, mac_a_idx, mac_b_idx;
    logic [DATA_W-1:0] elem_val, mac_prod;

    assign accept  = (state_reg == S_IDLE) && i_start;
    assign need_b  = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_MUL);
    assign elems_a = CNT_W'(a_m_reg) * CNT_W'(a_n_reg);
    assign elems_b = CNT_W'(b_m_reg) * CNT_W'(b_n_reg);
    assign elems_r = CNT_W'(res_m_reg) * CNT_W'(res_n_reg);

    assign in_load    = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
    assign load_elems = (state_reg == S_LOAD_B) ? elems_b : elems_a;
    assign load_base  = (state_reg == S_LOAD_B) ? b_addr_reg : a_addr_reg;
    assign load_last  = (cnt_reg == load_elems + LAT - CNT_W'(1));

    // In matrix mul an element completes on the extra cycle after its a_n MACs
    assign mul_store  = (op_reg == OP_MUL) && (k_reg == a_n_reg);
    assign calc_step  = (op_reg != OP_MUL) || mul_store;
    assign calc_last  = calc_step && (cnt_reg == elems_r - CNT_W'(1));
    assign write_last = (cnt_reg == elems_r - CNT_W'(1));

    // Buffer index arithmetic: transpose reads A(col,row); MAC walks A row and B column
    assign elem_idx  = BUF_AW'(cnt_reg);
    assign trn_idx   = BUF_AW'(CNT_W'(col_reg) * CNT_W'(a_n_reg) + CNT_W'(row_reg));
    assign mac_a_idx = BUF_AW'(CNT_W'(row_reg) * CNT_W'(a_n_reg) + CNT_W'(k_reg));
    assign mac_b_idx = BUF_AW'(CNT_W'(k_reg) * CNT_W'(b_n_reg) + CNT_W'(col_reg));
    assign mac_prod  = a_buf[mac_a_idx] * b_buf[mac_b_idx];

    // Operand validation (invalid op beats range beats mismatch) and result shape
    always_comb begin
        err_calc = 2'b00;
        calc_m   = a_m_reg;
        calc_n   = a_n_reg;
        if (op_reg > OP_SUB) begin
            err_calc = 2'b11;
        end else if (bad_dim(a_m_reg) || bad_dim(a_n_reg) ||
                     (need_b && (bad_dim(b_m_reg) || bad_dim(b_n_reg)))) begin
            err_calc = 2'b10;
        end else if (((op_reg == OP_ADD) || (op_reg == OP_SUB)) &&
                     ((a_m_reg != b_m_reg) || (a_n_reg != b_n_reg))) begin
            err_calc = 2'b01;
        end else if ((op_reg == OP_MUL) && (a_n_reg != b_m_reg)) begin
            err_calc = 2'b01;
        end
        if (op_reg == OP_TRN) begin
            calc_m = a_n_reg;
            calc_n = a_m_reg;
        end else if (op_reg == OP_MUL) begin
            calc_n = b_n_reg;
        end
    end

    // Single-cycle element result for the element-wise operations
    always_comb begin
        elem_val = acc_reg;
        case (op_reg)
            OP_TRN:  elem_val = a_buf[trn_idx];
            OP_ADD:  elem_val = a_buf[elem_idx] + b_buf[elem_idx];
            OP_SUB:  elem_val = a_buf[elem_idx] - b_buf[elem_idx];
            OP_SCL:  elem_val = a_buf[elem_idx] * scalar_reg;
            default: elem_val = acc_reg;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (i_start) state_next = S_CHECK;
            S_CHECK:  state_next = (err_calc != 2'b00) ? S_DONE : S_LOAD_A;
            S_LOAD_A: if (load_last) state_next = need_b ? S_LOAD_B : S_CALC;
            S_LOAD_B: if (load_last) state_next = S_CALC;
            S_CALC:   if (calc_last) state_next = S_WRITE;
            S_WRITE:  if (write_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Descriptor capture, status and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= '0;
            a_addr_reg   <= '0;
            b_addr_reg   <= '0;
            res_addr_reg <= '0;
            a_m_reg      <= '0;
            a_n_reg      <= '0;
            b_m_reg      <= '0;
            b_n_reg      <= '0;
            scalar_reg   <= '0;
            err_reg      <= '0;
            res_m_reg    <= '0;
            res_n_reg    <= '0;
            cnt_reg      <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            k_reg        <= '0;
            acc_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg       <= i_op;
                        a_addr_reg   <= i_a_addr;
                        b_addr_reg   <= i_b_addr;
                        res_addr_reg <= i_res_addr;
                        a_m_reg      <= i_a_m;
                        a_n_reg      <= i_a_n;
                        b_m_reg      <= i_b_m;
                        b_n_reg      <= i_b_n;
                        scalar_reg   <= i_scalar;
                        err_reg      <= '0;
                        res_m_reg    <= '0;
                        res_n_reg    <= '0;
                    end
                end
                S_CHECK: begin
                    err_reg <= err_calc;
                    cnt_reg <= '0;
                    if (err_calc == 2'b00) begin
                        res_m_reg <= calc_m;
                        res_n_reg <= calc_n;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (load_last) begin
                        cnt_reg <= '0;
                        row_reg <= '0;
                        col_reg <= '0;
                        k_reg   <= '0;
                        acc_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_CALC: begin
                    if (calc_step) begin
                        cnt_reg <= calc_last ? '0 : cnt_reg + CNT_W'(1);
                        acc_reg <= '0;
                        k_reg   <= '0;
                        if (col_reg == res_n_reg - 4'd1) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 4'd1;
                        end else begin
                            col_reg <= col_reg + 4'd1;
                        end
                    end else begin
                        acc_reg <= acc_reg + mac_prod;
                        k_reg   <= k_reg + 4'd1;
                    end
                end
                S_WRITE: cnt_reg <= cnt_reg + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Buffer writes: load capture RD_LAT cycles after each address, result store
    always_ff @(posedge clk) begin
        if (state_reg == S_LOAD_A && cnt_reg >= LAT)
            a_buf[BUF_AW'(cnt_reg - LAT)] <= i_rd_data;
        if (state_reg == S_LOAD_B && cnt_reg >= LAT)
            b_buf[BUF_AW'(cnt_reg - LAT)] <= i_rd_data;
        if (state_reg == S_CALC && calc_step)
            r_buf[elem_idx] <= elem_val;
    end

    assign o_busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign o_done    = (state_reg == S_DONE);
    assign o_err     = err_reg;
    assign o_res_m   = res_m_reg;
    assign o_res_n   = res_n_reg;
    assign o_rd_addr = (in_load && cnt_reg < load_elems) ? load_base + ADDR_W'(cnt_reg) : '0;
    assign o_we      = (state_reg == S_WRITE);
    assign o_waddr   = o_we ? res_addr_reg + ADDR_W'(cnt_reg) : '0;
    assign o_wdata   = o_we ? r_buf[elem_idx] : '0;

endmodule

// File: tb/tb_matrix_alu_core.sv
// Directed bench for matrix_alu_core with a latency-1 storage model.
module tb_matrix_alu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = '0;
    logic [7:0]  i_a_addr = '0, i_b_addr = '0, i_res_addr = '0;
    logic [3:0]  i_a_m = '0, i_a_n = '0, i_b_m = '0, i_b_n = '0;
    logic [31:0] i_scalar = '0;
    logic        o_busy, o_done, o_we;
    logic [1:0]  o_err;
    logic [3:0]  o_res_m, o_res_n;
    logic [7:0]  o_rd_addr, o_waddr;
    logic [31:0] i_rd_data = '0, o_wdata;

    matrix_alu_core #(.DATA_W(32), .ADDR_W(8), .MAX_DIM(5), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op),
        .i_a_addr(i_a_addr), .i_a_m(i_a_m), .i_a_n(i_a_n),
        .i_b_addr(i_b_addr), .i_b_m(i_b_m), .i_b_n(i_b_n),
        .i_scalar(i_scalar), .i_res_addr(i_res_addr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_res_m(o_res_m), .o_res_n(o_res_n), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          rd_cnt, b_rd_cnt;
    int          n_vec = 0, n_err = 0;
    int          busy_n, done_n;
    logic [1:0]  got_err;
    logic [3:0]  got_m, got_n;

    // Storage model: one-cycle registered read
    always @(posedge clk) i_rd_data <= mem[o_rd_addr];

    // Observe writes and reads away from the active edge
    always @(negedge clk) begin
        if (o_we) begin
            mem[o_waddr] = o_wdata;
            wr_addr_q.push_back(o_waddr);
            wr_data_q.push_back(o_wdata);
        end
        if (o_rd_addr != 8'h00) rd_cnt++;
        if (o_rd_addr >= 8'h20 && o_rd_addr <= 8'h25) b_rd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int i, input logic [7:0] addr, input logic [31:0] data);
        logic [7:0]  a = 8'hxx;
        logic [31:0] d = 32'hxxxxxxxx;
        if (i < wr_addr_q.size()) begin
            a = wr_addr_q[i];
            d = wr_data_q[i];
        end
        check({tag, "_addr"}, {24'h0, a}, {24'h0, addr});
        check({tag, "_data"}, d, data);
    endtask

    // Launch one operation, scramble inputs after acceptance, wait for done
    task automatic run(input logic [2:0] op, input logic [7:0] aa, input logic [3:0] am, input logic [3:0] an,
                       input logic [7:0] ba, input logic [3:0] bm, input logic [3:0] bn,
                       input logic [31:0] sc, input logic [7:0] ra, input int extra_start);
        bit seen = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_cnt = 0; b_rd_cnt = 0; busy_n = 0; done_n = 0;
        @(negedge clk);
        i_op = op; i_a_addr = aa; i_a_m = am; i_a_n = an;
        i_b_addr = ba; i_b_m = bm; i_b_n = bn; i_scalar = sc; i_res_addr = ra;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_op = 3'b111; i_a_addr = 8'hEE; i_a_m = 4'd9; i_a_n = 4'd0;
        i_b_addr = 8'hEE; i_b_m = 4'd0; i_b_n = 4'd9; i_scalar = 32'h5A5A; i_res_addr = 8'hEE;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                seen = 1; done_n = 1;
                got_err = o_err; got_m = o_res_m; got_n = o_res_n;
                check("busy_low_at_done", {31'h0, o_busy}, 32'h0);
            end else begin
                i_start = (c == extra_start) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        i_start = 1'b0;
        check("done_seen", {31'h0, seen}, 32'h1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done) done_n++;
        end
        check("done_pulses", done_n, 1);
        check("err_held", {30'h0, o_err}, {30'h0, got_err});
    endtask

    initial begin
        int exp_add[6] = '{11, 22, 33, 44, 55, 66};
        int exp_mul[4] = '{58, 64, 139, 154};
        int exp_trn[6] = '{1, 4, 2, 5, 3, 6};
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 6; i++) begin
            mem[8'h10 + i] = 32'(i + 1);
            mem[8'h20 + i] = 32'((i + 1) * 10);
            mem[8'h30 + i] = 32'(i + 7);
        end
        mem[8'h60] = 32'h0;
        mem[8'h61] = 32'h1;
        mem[8'h62] = 32'h8000_0000;

        // Reset state
        #12;
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_done", {31'h0, o_done}, 32'h0);
        check("rst_we", {31'h0, o_we}, 32'h0);
        check("rst_err_dims", {24'h0, o_err, o_res_m, o_res_n}, 32'h0);
        check("rst_addr", {16'h0, o_rd_addr, o_waddr}, 32'h0);
        check("rst_wdata", o_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add 2x3
        run(3'b001, 8'h10, 4'd2, 4'd3, 8'h20, 4'd2, 4'd3, 32'h0, 8'h40, -1);
        check("add_err", {30'h0, got_err}, 32'h0);
        check("add_dims", {24'h0, got_m, got_n}, 32'h23);
        check("add_nwr", wr_addr_q.size(), 6);
        for (int i = 0; i < 6; i++) check_wr("add_wr", i, 8'(8'h40 + i), 32'(exp_add[i]));
        check("add_busy", busy_n, 27);

        // Matrix mul 2x3 * 3x2: 12 MAC + 4 store cycles in CALC
        run(3'b011, 8'h10, 4'd2, 4'd3, 8'h30, 4'd3, 4'd2, 32'h0, 8'h50, -1);
        check("mul_err", {30'h0, got_err}, 32'h0);
        check("mul_dims", {24'h0, got_m, got_n}, 32'h22);
        check("mul_nwr", wr_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) check_wr("mul_wr", i, 8'(8'h50 + i), 32'(exp_mul[i]));
        check("mul_busy", busy_n, 35);

        // Transpose 2x3
        run(3'b000, 8'h10, 4'd2, 4'd3, 8'h20, 4'd2, 4'd3, 32'h0, 8'h70, -1);
        check("trn_dims", {24'h0, got_m, got_n}, 32'h32);
        check("trn_nwr", wr_addr_q.size(), 6);
        for (int i = 0; i < 6; i++) check_wr("trn_wr", i, 8'(8'h70 + i), 32'(exp_trn[i]));
        check("trn_b_reads", b_rd_cnt, 0);
        check("trn_busy", busy_n, 20);

        // Wrap-around: 0-1 and 0x80000000*2
        run(3'b100, 8'h60, 4'd1, 4'd1, 8'h61, 4'd1, 4'd1, 32'h0, 8'h80, -1);
        check("sub_nwr", wr_addr_q.size(), 1);
        check_wr("sub_wr", 0, 8'h80, 32'hFFFF_FFFF);
        run(3'b010, 8'h62, 4'd1, 4'd1, 8'h20, 4'd0, 4'd0, 32'h2, 8'h81, -1);
        check("scl_err", {30'h0, got_err}, 32'h0);
        check_wr("scl_wr", 0, 8'h81, 32'h0);

        // Errors: mismatch, range, invalid op (op beats range)
        run(3'b011, 8'h10, 4'd2, 4'd3, 8'h30, 4'd2, 4'd2, 32'h0, 8'h90, -1);
        check("mm_err", {30'h0, got_err}, 32'h1);
        check("mm_dims", {24'h0, got_m, got_n}, 32'h0);
        check("mm_nwr", wr_addr_q.size(), 0);
        check("mm_reads", rd_cnt, 0);
        check("mm_busy", busy_n, 1);
        run(3'b000, 8'h10, 4'd6, 4'd1, 8'h20, 4'd0, 4'd0, 32'h0, 8'h90, -1);
        check("rng_err", {30'h0, got_err}, 32'h2);
        check("rng_nwr", wr_addr_q.size(), 0);
        run(3'b111, 8'h10, 4'd0, 4'd1, 8'h20, 4'd1, 4'd1, 32'h0, 8'h90, -1);
        check("op_err", {30'h0, got_err}, 32'h3);

        // Asynchronous reset in the middle of WRITE
        @(negedge clk);
        i_op = 3'b001; i_a_addr = 8'h10; i_a_m = 4'd2; i_a_n = 4'd3;
        i_b_addr = 8'h20; i_b_m = 4'd2; i_b_n = 4'd3; i_res_addr = 8'hA0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 100 && !o_we; c++) @(negedge clk);
        check("mid_we_reached", {31'h0, o_we}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'h0, o_we}, 32'h0);
        check("arst_busy", {31'h0, o_busy}, 32'h0);
        check("arst_wdata", o_wdata, 32'h0);
        check("arst_waddr", {24'h0, o_waddr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh add after reset, with a stray start during LOAD_A
        run(3'b001, 8'h10, 4'd2, 4'd3, 8'h20, 4'd2, 4'd3, 32'h0, 8'hB0, 3);
        check("post_err", {30'h0, got_err}, 32'h0);
        check("post_nwr", wr_addr_q.size(), 6);
        for (int i = 0; i < 6; i++) check_wr("post_wr", i, 8'(8'hB0 + i), 32'(exp_add[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
